tc_timer: RTL and testbench



---
 rtl/tc_pkg.sv | 41 ++++
 rtl/tc_bytemerge.sv | 23 ++
 rtl/tc_timer.sv | 212 +++++++++++++++++++++
 tb/tb_tc_timer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared types and constants for the tc_timer device
//
// Contents:
//   tc_state_e   : counter sequencer states (IDLE, LOAD, CNT, INT)
//   OFF_*        : word offsets inside the device window
//   CTRL_*       : bit positions inside the CTRL register
//   MODE_*       : CTRL.Mode encodings (codes 2/3 behave as one-shot)
//   lane_mask()  : expands a 4-bit byte enable into a 32-bit bit mask

package tc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_EXT    = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  function automatic logic [31:0] lane_mask(input logic [3:0] byteen);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{byteen[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/tc_bytemerge.sv
// rtl/tc_bytemerge.sv - byte-lane merge of write data into a register value
//
// Ports:
//   cur    in  32  current register contents
//   wdata  in  32  bus write data
//   byteen in  4   lanes of wdata to take; other lanes keep cur
//   merged out 32  resulting register value (purely combinational)

module tc_bytemerge
  import tc_pkg::*;
(
  input  logic [31:0] cur,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] merged
);

  logic [31:0] mask;

  assign mask   = lane_mask(byteen);
  assign merged = (cur & ~mask) | (wdata & mask);

endmodule

// File: rtl/tc_timer.sv
// rtl/tc_timer.sv - memory-mapped 32-bit down-counting timer with irq
//
// Parameters:
//   DEFAULT_PRESET  reset value of PRESET
//   DEFAULT_CTRL    reset value of CTRL (bits [3:0] kept)
// Ports:
//   clk     in  1   system clock, rising edge
//   reset   in  1   synchronous active-high reset
//   addr    in  2   word offset: 0=CTRL 1=PRESET 2=COUNT 3=EXT
//   we      in  1   write strobe (already qualified by device select)
//   byteen  in  4   byte lanes of wdata to write
//   wdata   in  32  write data
//   rdata   out 32  combinational read data for addr
//   irq     out 1   irq_flag & CTRL.IM
// Build option:
//   TC_WRAP_CNT_EN  adds a wrapping expiration counter readable at EXT;
//                   without it EXT reads zero.

module tc_timer
  import tc_pkg::*;
#(
  parameter logic [31:0] DEFAULT_PRESET = 32'd0,
  parameter logic [31:0] DEFAULT_CTRL   = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_e   state_q;
  tc_state_e   state_d;

  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;
  logic [31:0] ext_rdata;

  // sequencer actions decoded from the current state
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_clear;
  logic        flag_set;
  logic        flag_hw_clr;
  logic        en_hw_clr;

  logic        ctrl_wr;
  logic        preset_wr;
  logic [31:0] ctrl_merged;
  logic [31:0] preset_merged;
  logic [27:0] unused_ctrl_hi;

  logic        ctrl_en;
  logic [1:0]  ctrl_mode;

  assign ctrl_en   = ctrl_q[CTRL_EN];
  assign ctrl_mode = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

  // A CTRL write with no lanes enabled is not a write at all, so it must
  // not clear the pending irq either.
  assign ctrl_wr   = we && (addr == OFF_CTRL) && (byteen != 4'd0);
  assign preset_wr = we && (addr == OFF_PRESET);

  tc_bytemerge u_ctrl_merge (
    .cur    ({28'd0, ctrl_q}),
    .wdata  (wdata),
    .byteen (byteen),
    .merged (ctrl_merged)
  );

  tc_bytemerge u_preset_merge (
    .cur    (preset_q),
    .wdata  (wdata),
    .byteen (byteen),
    .merged (preset_merged)
  );

  // CTRL only stores the low nibble; upper merged bits are discarded.
  assign unused_ctrl_hi = ctrl_merged[31:4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    cnt_clear   = 1'b0;
    flag_set    = 1'b0;
    flag_hw_clr = 1'b0;
    en_hw_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_en) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_load = 1'b1;
        state_d  = CNT;
      end
      CNT: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          cnt_dec = 1'b1;
        end else begin
          // COUNT of 0 or 1 both expire here, which is what makes a
          // PRESET of 0 behave like 1.
          cnt_clear = 1'b1;
          flag_set  = 1'b1;
          state_d   = INT;
        end
      end
      INT: begin
        state_d = IDLE;
        if (ctrl_mode == MODE_RELOAD) begin
          flag_hw_clr = 1'b1;
        end else begin
          en_hw_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A CPU write to CTRL overrides the hardware Enable clear in INT.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= DEFAULT_CTRL[3:0];
    end else if (ctrl_wr) begin
      ctrl_q <= ctrl_merged[3:0];
    end else if (en_hw_clr) begin
      ctrl_q[CTRL_EN] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      preset_q <= DEFAULT_PRESET;
    end else if (preset_wr) begin
      preset_q <= preset_merged;
    end
  end

  // COUNT is only ever touched by the sequencer; bus writes never reach it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (cnt_load) begin
      count_q <= preset_q;
    end else if (cnt_dec) begin
      count_q <= count_q - 32'd1;
    end else if (cnt_clear) begin
      count_q <= 32'd0;
    end
  end

  // Expiry takes priority over a same-edge CPU clear so an irq is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_flag_q <= 1'b0;
    end else if (flag_set) begin
      irq_flag_q <= 1'b1;
    end else if (ctrl_wr || flag_hw_clr) begin
      irq_flag_q <= 1'b0;
    end
  end

  assign irq = irq_flag_q & ctrl_q[CTRL_IM];

`ifdef TC_WRAP_CNT_EN
  logic [31:0] expire_cnt_q;

  // flag_set is asserted exactly on the CNT->INT transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      expire_cnt_q <= 32'd0;
    end else if (flag_set) begin
      expire_cnt_q <= expire_cnt_q + 32'd1;
    end
  end

  assign ext_rdata = expire_cnt_q;
`else
  assign ext_rdata = 32'd0;
`endif

  always_comb begin
    rdata = 32'd0;
    case (addr)
      OFF_CTRL:   rdata = {28'd0, ctrl_q};
      OFF_PRESET: rdata = preset_q;
      OFF_COUNT:  rdata = count_q;
      OFF_EXT:    rdata = ext_rdata;
      default:    rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_tc_timer.sv
// tb/tb_tc_timer.sv - randomized self-checking bench for tc_timer

module tb_tc_timer;
  import tc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [3:0]  byteen = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp = 0;
  int n_mis = 0;

  // reference state, tracked per scenario
  int unsigned preset_m = 0;
  int unsigned count_m  = 0;
  int unsigned ext_m    = 0;

  tc_timer dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic w, input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    we = w; addr = a; byteen = be; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0; byteen = 4'd0;
  endtask

  task automatic idle();
    step(1'b0, OFF_COUNT, 4'd0, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  // Expected COUNT k edges after the enabling write: untouched before the
  // load, then PRESET counting down by one per edge, floored at zero.
  function automatic int unsigned count_at(input int p, input int k, input int unsigned prev);
    if (k < 2) return prev;
    if (p > k - 2) return p - (k - 2);
    return 0;
  endfunction

  function automatic int expire_k(input int p);
    return ((p < 1) ? 1 : p) + 2;
  endfunction

  function automatic logic [31:0] ext_exp(input int unsigned extra);
`ifdef TC_WRAP_CNT_EN
    return ext_m + extra;
`else
    return 32'd0 + 0 * extra;
`endif
  endfunction

  task automatic check_reset_state(input string tag);
    logic [31:0] v;
    rd(OFF_CTRL, v);   check_val({tag, "_ctrl"}, v, 32'd0);
    rd(OFF_PRESET, v); check_val({tag, "_preset"}, v, 32'd0);
    rd(OFF_COUNT, v);  check_val({tag, "_count"}, v, 32'd0);
    rd(OFF_EXT, v);    check_val({tag, "_ext"}, v, 32'd0);
    check_val({tag, "_irq"}, {31'd0, irq}, 32'd0);
    preset_m = 0; count_m = 0; ext_m = 0;
  endtask

  // One-shot run. At most one of: race (CTRL rewrite on the expiry edge),
  // pre_wr_at (PRESET rewrite mid-count), abort_at (Enable cleared mid-count).
  task automatic run_oneshot(input int p, input logic [1:0] mode, input logic im,
                             input bit race, input int pre_wr_at, input int abort_at);
    logic [31:0] v;
    logic [31:0] ctrl_on;
    logic [31:0] ctrl_off;
    int ke;
    int last;
    int unsigned p_new;
    ctrl_on  = {28'd0, im, mode, 1'b1};
    ctrl_off = {28'd0, im, mode, 1'b0};
    ke = expire_k(p);
    last = (abort_at != 0) ? abort_at : ke + 2;
    p_new = $urandom_range(0, 12);
    step(1'b1, OFF_PRESET, 4'hF, p);
    preset_m = p;
    step(1'b1, OFF_CTRL, 4'h1, ctrl_on);
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        if (abort_at != 0 && k == abort_at) step(1'b1, OFF_CTRL, 4'h1, ctrl_off);
        else if (race && k == ke) step(1'b1, OFF_CTRL, 4'h1, ctrl_on);
        else if (k == pre_wr_at) begin
          step(1'b1, OFF_PRESET, 4'hF, p_new);
          preset_m = p_new;
        end else idle();
      end
      rd(OFF_COUNT, v);
      check_val("os_count", v, count_at(p, k, count_m));
      check_val("os_irq", {31'd0, irq}, {31'd0, im && (k >= ke)});
      rd(OFF_CTRL, v);
      if (abort_at != 0 && k == abort_at) check_val("os_ctrl", v, ctrl_off);
      else check_val("os_ctrl", v, (k <= ke) ? ctrl_on : ctrl_off);
    end
    if (abort_at != 0) begin
      count_m = count_at(p, abort_at, count_m);
      for (int i = 0; i < 3; i++) begin
        idle();
        rd(OFF_COUNT, v);
        check_val("abort_count_hold", v, count_m);
        check_val("abort_irq", {31'd0, irq}, 32'd0);
      end
    end else begin
      rd(OFF_PRESET, v);
      check_val("os_preset", v, preset_m);
      step(1'b1, OFF_CTRL, 4'h1 | 4'($urandom_range(0, 15)), ($urandom & 32'hFFFF_FFF0) | ctrl_off);
      check_val("os_irq_cleared", {31'd0, irq}, 32'd0);
      rd(OFF_CTRL, v);
      check_val("os_ctrl_after_clr", v, ctrl_off);
      count_m = 0;
    end
    rd(OFF_EXT, v);
    check_val("os_ext", v, ext_exp((abort_at != 0) ? 0 : 1));
    if (abort_at == 0) ext_m += 1;
  endtask

  // Auto-reload run for exactly four periods, then disabled.
  task automatic run_reload(input int p, input logic im);
    logic [31:0] v;
    logic [31:0] ctrl_on;
    int per;
    int n;
    int j;
    int unsigned cexp;
    int unsigned nexp;
    ctrl_on = {28'd0, im, MODE_RELOAD, 1'b1};
    per = p + 3;
    step(1'b1, OFF_PRESET, 4'hF, p);
    preset_m = p;
    step(1'b1, OFF_CTRL, 4'h1, ctrl_on);
    for (int k = 0; k < 4 * per; k++) begin
      if (k > 0) idle();
      n = k / per;
      j = k % per;
      cexp = count_at(p, j, (n == 0) ? count_m : 0);
      nexp = (k >= p + 2) ? (k - (p + 2)) / per + 1 : 0;
      rd(OFF_COUNT, v);
      check_val("rl_count", v, cexp);
      check_val("rl_irq", {31'd0, irq}, {31'd0, im && (j == p + 2)});
      rd(OFF_CTRL, v);
      check_val("rl_ctrl", v, ctrl_on);
      rd(OFF_EXT, v);
      check_val("rl_ext", v, ext_exp(nexp));
    end
    ext_m += 4;
    step(1'b1, OFF_CTRL, 4'h1, 32'd0);
    check_val("rl_stop_irq", {31'd0, irq}, 32'd0);
    rd(OFF_CTRL, v);
    check_val("rl_stop_ctrl", v, 32'd0);
    idle();
    idle();
    rd(OFF_COUNT, v);
    check_val("rl_stop_count", v, 32'd0);
    count_m = 0;
  endtask

  initial begin
    logic [31:0] v;
    int p;
    int sel;

    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    check_reset_state("reset");

    run_oneshot(5, MODE_ONESHOT, 1'b1, 1'b0, 0, 0);
    run_reload(3, 1'b1);
    run_oneshot(6, MODE_ONESHOT, 1'b1, 1'b0, 0, 5);
    run_oneshot(6, MODE_ONESHOT, 1'b1, 1'b0, 0, 0);
    run_oneshot(0, MODE_ONESHOT, 1'b1, 1'b0, 0, 0);

    step(1'b1, OFF_PRESET, 4'hF, 32'h1122_3344);
    step(1'b1, OFF_PRESET, 4'b0101, 32'hAABB_CCDD);
    rd(OFF_PRESET, v);
    check_val("lane_merge", v, 32'h11BB_33DD);
    step(1'b1, OFF_PRESET, 4'b0000, 32'h5555_5555);
    rd(OFF_PRESET, v);
    check_val("lane_none", v, 32'h11BB_33DD);
    step(1'b1, OFF_COUNT, 4'hF, 32'hDEAD_BEEF);
    rd(OFF_COUNT, v);
    check_val("count_ro", v, count_m);
    step(1'b1, OFF_EXT, 4'hF, 32'hDEAD_BEEF);
    rd(OFF_EXT, v);
    check_val("ext_ro", v, ext_exp(0));
    step(1'b1, OFF_CTRL, 4'b1110, 32'hFFFF_FFFF);
    rd(OFF_CTRL, v);
    check_val("ctrl_lane0_only", v, {28'd0, 1'b1, MODE_ONESHOT, 1'b0});

    for (int it = 0; it < 14; it++) begin
      sel = $urandom_range(0, 4);
      p = $urandom_range(0, 12);
      case (sel)
        0: run_oneshot(p, 2'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(2, 3)),
                       1'($urandom_range(0, 1)), 1'b0, 0, 0);
        1: run_oneshot(p, MODE_ONESHOT, 1'b1, 1'b1, 0, 0);
        2: run_oneshot(p, 2'($urandom_range(2, 3)), 1'b1, 1'b0,
                       (expire_k(p) - 1 >= 3) ? $urandom_range(3, expire_k(p) - 1) : 0, 0);
        3: begin
          p = $urandom_range(2, 12);
          run_oneshot(p, MODE_ONESHOT, 1'($urandom_range(0, 1)), 1'b0, 0, $urandom_range(2, p + 1));
        end
        default: run_reload($urandom_range(1, 6), 1'($urandom_range(0, 1)));
      endcase
    end

    // reset in the middle of a count
    step(1'b1, OFF_PRESET, 4'hF, 32'd10);
    step(1'b1, OFF_CTRL, 4'h1, 32'h9);
    for (int i = 0; i < 5; i++) idle();
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check_reset_state("rst_mid_cnt");
    idle();
    idle();
    rd(OFF_COUNT, v);
    check_val("rst_mid_cnt_idle", v, 32'd0);

    // reset with an expired, latched irq
    step(1'b1, OFF_PRESET, 4'hF, 32'd1);
    step(1'b1, OFF_CTRL, 4'h1, 32'h9);
    for (int i = 0; i < 4; i++) idle();
    check_val("pre_rst_irq", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check_reset_state("rst_pending");
    idle();
    check_val("rst_pending_irq_stays", {31'd0, irq}, 32'd0);

    run_oneshot(4, MODE_ONESHOT, 1'b1, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
